// File: rtl/mac_accumulator.sv
// Serial signed multiply-accumulate: loads a binary-point-aligned bias, sums N x*w products,
// then holds the full-precision result behind a valid/ready handshake for the saturation stage.
module mac_accumulator #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [WIDTH-1:0]       bias_in,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WIDTH-1:0]       x_in,
    input  logic signed [WIDTH-1:0]       w_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [2*WIDTH+N-1:0]   acc_out
);

    localparam int unsigned AccW     = 2 * WIDTH + N;
    localparam int unsigned FracBits = (WIDTH == 8) ? 5 : (WIDTH == 16) ? 10 : 20;
    localparam int unsigned CntW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                   state_q;
    logic signed [AccW-1:0]   acc_q;
    logic [CntW-1:0]          cnt_q;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [AccW-1:0]    prod_ext;
    logic signed [AccW-1:0]    bias_aligned;
    logic                      beat;

    assign prod         = x_in * w_in;
    assign prod_ext     = {{N{prod[2*WIDTH-1]}}, prod};
    // Bias is Q(INT).(FRAC); products carry 2*FRAC fraction bits, so shift by FRAC.
    assign bias_aligned = {{(AccW - WIDTH){bias_in[WIDTH-1]}}, bias_in} << FracBits;
    assign beat         = in_valid && (state_q == StAccum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= bias_aligned;
                        cnt_q   <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (beat) begin
                        acc_q <= acc_q + prod_ext;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastBeat) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake outputs decode the registered state only.
    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StAccum) || (state_q == StDone);
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator (WIDTH=8, N=4) with hand-computed Q6.10 results.
module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bias_in;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_in;
    logic [7:0]  w_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] acc_out;

    int checks;
    int failures;

    mac_accumulator #(.N(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias_in   (bias_in),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b);
        start   = 1'b1;
        bias_in = b;
        step();
        start   = 1'b0;
    endtask

    task automatic do_beat(input logic [7:0] x, input logic [7:0] w);
        in_valid = 1'b1;
        x_in     = x;
        w_in     = w;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        bias_in   = '0;
        in_valid  = 1'b0;
        x_in      = '0;
        w_in      = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc", acc_out, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Test 1: 4 x (1.0*1.0), bias 0 -> 4.0
        do_start(8'h00);
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_bias_acc", acc_out, 20'h00000);
        for (int i = 0; i < 4; i++) begin
            chk("t1_no_valid_yet", out_valid, 0);
            do_beat(8'h20, 8'h20);
        end
        chk("t1_out_valid", out_valid, 1);
        chk("t1_in_ready_done", in_ready, 0);
        chk("t1_acc", acc_out, 20'h01000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_busy_drop", busy, 0);

        // Test 2: bias 0.5, 4 x (2.0*-1.0) -> -7.5
        do_start(8'h10);
        chk("t2_bias_acc", acc_out, 20'h00200);
        for (int i = 0; i < 4; i++) do_beat(8'h40, 8'hE0);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_acc", acc_out, 20'hFE200);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Test 3: extremes, bias -4.0, 4 x (-4.0*-4.0) -> 60.0
        do_start(8'h80);
        chk("t3_bias_acc", acc_out, 20'hFF000);
        for (int i = 0; i < 4; i++) do_beat(8'h80, 8'h80);
        chk("t3_acc", acc_out, 20'h0F000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Test 4: bubbles between beats 2 and 3, backpressure and ignored start in DONE
        do_start(8'h08);
        do_beat(8'h20, 8'h20);
        do_beat(8'h10, 8'h40);
        chk("t4_acc_beat2", acc_out, 20'h00900);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_bubble_acc", acc_out, 20'h00900);
            chk("t4_bubble_ready", in_ready, 1);
            chk("t4_bubble_valid", out_valid, 0);
        end
        do_beat(8'hF0, 8'h20);
        chk("t4_still_accum", out_valid, 0);
        do_beat(8'h7F, 8'h7F);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_acc", acc_out, 20'h04601);
            chk("t4_hold_ready", in_ready, 0);
            start   = (i == 2);
            bias_in = 8'h7F;
            step();
        end
        start = 1'b0;
        chk("t4_after_start_acc", acc_out, 20'h04601);
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("t4_valid_drop", out_valid, 0);
        step();
        chk("t4_start_in_done_ignored", busy, 0);

        // Test 5: asynchronous reset after two accepted beats
        do_start(8'h00);
        do_beat(8'h20, 8'h20);
        do_beat(8'h20, 8'h20);
        chk("t5_acc_beat2", acc_out, 20'h00800);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_acc", acc_out, 0);
        step();
        rst_n = 1'b1;
        step();
        do_start(8'h00);
        for (int i = 0; i < 4; i++) do_beat(8'h20, 8'h20);
        chk("t5_rerun_valid", out_valid, 1);
        chk("t5_rerun_acc", acc_out, 20'h01000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Test 6: start held through ACCUM must not reload the bias
        start   = 1'b1;
        bias_in = 8'h10;
        step();
        bias_in = 8'h7F;
        for (int i = 0; i < 4; i++) begin
            step();
            do_beat(8'h40, 8'hE0);
        end
        chk("t6_out_valid", out_valid, 1);
        chk("t6_acc", acc_out, 20'hFE200);
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_valid_drop", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
